// File: rtl/pwl_sched_pkg.sv
// pwl_sched_pkg: shared types for the PWL tanh scheduler.
// Holds the Q8.8 word width, the scheduler state encoding and the
// tag carried alongside each operand through the evaluator pipeline.
package pwl_sched_pkg;

  // Q8.8 signed fixed point word width
  localparam int Q_W = 16;

  // Tag index is sized for the largest supported requester count (8)
  localparam int TAG_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/pwl_rr_picker.sv
// pwl_rr_picker: combinational round-robin priority select.
// Scans the eligible mask starting at ptr and wrapping, returning the
// first eligible requester as a one-hot grant plus its binary index.
module pwl_rr_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Walk candidates ptr, ptr+1, ... (mod N) and latch the first eligible one
  always_comb begin
    int          cand;
    logic [PW-1:0] cand_idx;
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = PW'(cand);
      if (!any && eligible[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/pwl_tanh_sched.sv
// pwl_tanh_sched: round-robin scheduler sharing one PWL tanh evaluator
// among NUM_REQ requesters. One operand is accepted per cycle, launched
// into the evaluator with a tag, and the result is routed back into a
// one-entry response slot owned by the originating requester.
// Optional feature macro: PWL_SCHED_STATS_EN adds saturating issue_cnt
// and stall_cnt outputs.
module pwl_tanh_sched
  import pwl_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PWL_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*Q_W-1:0] req_x,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [NUM_REQ*Q_W-1:0] resp_y,
  output logic                   pwl_valid_in,
  output logic [Q_W-1:0]         pwl_x,
  input  logic                   pwl_valid_out,
  input  logic [Q_W-1:0]         pwl_y,
  output logic                   busy,
  output logic                   err
`ifdef PWL_SCHED_STATS_EN
  ,
  output logic [31:0]            issue_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_t         state;
  sched_state_t         state_next;
  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   inflight;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_any;
  logic                 accept;
  tag_t                 tag_out;

  // Stage 0 is the launch stage (aligned with pwl_valid_in); the remaining
  // PWL_LAT stages track the evaluator so tag_sr[PWL_LAT] meets pwl_valid_out.
  tag_t                 tag_sr [PWL_LAT+1];

  assign tag_out = tag_sr[PWL_LAT];

  // Mark every requester that still has an operand somewhere in the pipe
  always_comb begin
    inflight = '0;
    for (int s = 0; s <= PWL_LAT; s++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tag_sr[s].valid && (tag_sr[s].idx == TAG_IDX_W'(i))) begin
          inflight[i] = 1'b1;
        end
      end
    end
  end

  // Only RUN with en high may grant; a requester needs an empty slot and
  // no outstanding op, which keeps at most one op per requester alive.
  always_comb begin
    eligible = '0;
    if ((state == RUN) && en) begin
      eligible = req_valid & ~resp_valid & ~inflight;
    end
  end

  pwl_rr_picker #(
    .N  (NUM_REQ),
    .PW (IDX_W)
  ) u_picker (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (grant),
    .idx      (win_idx),
    .any      (win_any)
  );

  // Ready is suppressed while reset is asserted so nothing is handshaken
  always_comb begin
    req_ready = rst_n ? grant : '0;
    accept    = rst_n & win_any;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: DRAIN waits until the pipe and all slots are empty
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = DRAIN;
      DRAIN: begin
        if (en)                                state_next = RUN;
        else if (~|inflight && ~|resp_valid)   state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Round-robin pointer moves just past the winner on every accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      if (win_idx == IDX_W'(NUM_REQ - 1)) rr_ptr <= '0;
      else                                rr_ptr <= win_idx + IDX_W'(1);
    end
  end

  // Launch register: one-cycle pwl_valid_in pulse with the winner's operand
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwl_valid_in <= 1'b0;
      pwl_x        <= '0;
    end else begin
      pwl_valid_in <= accept;
      if (accept) pwl_x <= req_x[Q_W*win_idx +: Q_W];
    end
  end

  // Tag pipeline follows the operand through the evaluator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s <= PWL_LAT; s++) tag_sr[s] <= '0;
    end else begin
      tag_sr[0].valid <= accept;
      tag_sr[0].idx   <= TAG_IDX_W'(win_idx);
      for (int s = 1; s <= PWL_LAT; s++) tag_sr[s] <= tag_sr[s-1];
    end
  end

  // Response slots: fill from the evaluator by tag, empty on consumer handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_y     <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pwl_valid_out && tag_out.valid && (tag_out.idx == TAG_IDX_W'(i))) begin
          resp_y[Q_W*i +: Q_W] <= pwl_y;
          resp_valid[i]        <= 1'b1;
        end else if (resp_valid[i] && resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky error when evaluator output and tag pipeline disagree
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (pwl_valid_out != tag_out.valid) begin
      err <= 1'b1;
    end
  end

`ifdef PWL_SCHED_STATS_EN
  // Saturating counters of accepts and of RUN cycles with demand but no grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && (issue_cnt != '1)) issue_cnt <= issue_cnt + 32'd1;
      if ((state == RUN) && (|req_valid) && !accept && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
